// File: rtl/dma_sequencer_param.sv
// Parametrised single-mode DMA sequencer: NUM_CH channels, fixed or
// rotating priority, SI/S0..S4 transfer FSM with HRQ/HLDA handshake.
module dma_sequencer_param #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_CH-1:0]          DREQ,
    input  logic                       HLDA,
    input  logic                       rotatePriority,
    input  logic                       progValid,
    input  logic [$clog2(NUM_CH)-1:0]  progChannel,
    input  logic [ADDR_W-1:0]          progAddr,
    input  logic [COUNT_W-1:0]         progCount,
    input  logic [2:0]                 progMode,
    output logic                       progAccept,
    input  logic                       statusRead,
    output logic                       HRQ,
    output logic [NUM_CH-1:0]          DACK,
    output logic                       AEN,
    output logic                       ADSTB,
    output logic [ADDR_W-1:0]          ADDR,
    output logic                       MEMR_N,
    output logic                       MEMW_N,
    output logic                       IOR_N,
    output logic                       IOW_N,
    output logic                       TC,
    output logic [NUM_CH-1:0]          tcStatus,
    output logic [NUM_CH-1:0]          armed
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_base_addr [NUM_CH];
    logic [ADDR_W-1:0]  r_cur_addr  [NUM_CH];
    logic [COUNT_W-1:0] r_base_cnt  [NUM_CH];
    logic [COUNT_W-1:0] r_cur_cnt   [NUM_CH];
    logic [2:0]         r_mode      [NUM_CH];
    logic [NUM_CH-1:0]  r_armed;
    logic [NUM_CH-1:0]  r_tc;
    logic [CH_W-1:0]    r_grant;
    logic [CH_W-1:0]    r_top;

    logic [NUM_CH-1:0]  w_elig;
    logic               w_any;
    logic [CH_W-1:0]    w_top;
    logic [CH_W-1:0]    w_pick;
    logic [CH_W-1:0]    w_idx;
    logic               w_found;
    logic               w_accept;
    logic               w_grant_edge;
    logic               w_last;
    logic               w_rd;
    logic               w_wr;
    logic               w_dir;

    assign w_elig       = DREQ & r_armed;
    assign w_any        = |w_elig;
    assign w_top        = rotatePriority ? r_top : '0;
    assign w_accept     = progValid && (r_state == SI || r_state == S0)
                          && (int'(progChannel) < NUM_CH);
    assign w_grant_edge = (r_state == S0) && HLDA && w_any;
    assign w_last       = (r_cur_cnt[r_grant] == '0);
    assign progAccept   = w_accept;
    assign tcStatus     = r_tc;
    assign armed        = r_armed;

    // Search starts at the current top-priority channel and wraps around.
    always_comb begin
        w_pick  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = CH_W'((int'(w_top) + k) % NUM_CH);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= SI;
            r_grant <= '0;
            r_top   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_edge)
                r_grant <= w_pick;
            if (!rotatePriority)
                r_top <= '0;
            else if (r_state == S4)
                r_top <= (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SI: if (w_any) w_next = S0;
            S0: begin
                if (!w_any)    w_next = SI;
                else if (HLDA) w_next = S1;
            end
            S1: w_next = S2;
            S2: w_next = S3;
            S3: w_next = S4;
            S4: w_next = SI;
            default: w_next = SI;
        endcase
    end

    always_comb begin
        HRQ   = 1'b0;
        AEN   = 1'b0;
        ADSTB = 1'b0;
        DACK  = '0;
        w_rd  = 1'b0;
        w_wr  = 1'b0;
        unique case (r_state)
            SI: HRQ = 1'b0;
            S0: HRQ = 1'b1;
            S1: begin
                HRQ   = 1'b1;
                AEN   = 1'b1;
                ADSTB = 1'b1;
            end
            S2: begin
                HRQ           = 1'b1;
                AEN           = 1'b1;
                DACK[r_grant] = 1'b1;
                w_rd          = 1'b1;
            end
            S3, S4: begin
                HRQ           = 1'b1;
                AEN           = 1'b1;
                DACK[r_grant] = 1'b1;
                w_rd          = 1'b1;
                w_wr          = 1'b1;
            end
            default: HRQ = 1'b0;
        endcase
        w_dir  = r_mode[r_grant][0];
        ADDR   = AEN ? r_cur_addr[r_grant] : '0;
        MEMR_N = !(w_rd && !w_dir);
        IOR_N  = !(w_rd && w_dir);
        IOW_N  = !(w_wr && !w_dir);
        MEMW_N = !(w_wr && w_dir);
        TC     = (r_state == S4) && w_last;
    end

    // Programming is blocked in S1..S4, so it never collides with S4 updates.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_base_addr[i] <= '0;
                r_cur_addr[i]  <= '0;
                r_base_cnt[i]  <= '0;
                r_cur_cnt[i]   <= '0;
                r_mode[i]      <= '0;
            end
            r_armed <= '0;
            r_tc    <= '0;
        end else begin
            if (statusRead)
                r_tc <= '0;
            if (w_accept) begin
                r_base_addr[progChannel] <= progAddr;
                r_cur_addr[progChannel]  <= progAddr;
                r_base_cnt[progChannel]  <= progCount;
                r_cur_cnt[progChannel]   <= progCount;
                r_mode[progChannel]      <= progMode;
                r_armed[progChannel]     <= 1'b1;
                r_tc[progChannel]        <= 1'b0;
            end
            if (r_state == S4) begin
                if (r_mode[r_grant][2])
                    r_cur_addr[r_grant] <= r_cur_addr[r_grant] - 1'b1;
                else
                    r_cur_addr[r_grant] <= r_cur_addr[r_grant] + 1'b1;
                if (w_last) begin
                    r_tc[r_grant] <= 1'b1;
                    if (r_mode[r_grant][1]) begin
                        r_cur_addr[r_grant] <= r_base_addr[r_grant];
                        r_cur_cnt[r_grant]  <= r_base_cnt[r_grant];
                    end else begin
                        r_armed[r_grant] <= 1'b0;
                    end
                end else begin
                    r_cur_cnt[r_grant] <= r_cur_cnt[r_grant] - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dma_sequencer_param.md
Name: dma_sequencer_param

Overview:
- Parametrised successor to the fixed 4-channel DMA timing-and-control/priority pair.
- Services NUM_CH DREQ lines with selectable fixed or rotating priority.
- Runs one single-mode transfer per grant through the SI/S0/S1/S2/S3/S4 state machine, with the HRQ/HLDA bus handshake.
- Keeps per-channel base/current address and count, with auto-initialise, address decrement and sticky terminal-count status.

Parameters:
- NUM_CH, 4, number of DMA channels (2..8)
- ADDR_W, 16, address register and ADDR width
- COUNT_W, 16, word-count register width (count = transfers-1)

Ports:
- CLK  in  1  system clock, all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- DREQ  in  NUM_CH  channel requests, active high
- HLDA  in  1  hold acknowledge from CPU
- rotatePriority  in  1  0=fixed (ch0 highest), 1=rotating
- progValid  in  1  program-channel strobe
- progChannel  in  $clog2(NUM_CH)  channel to program
- progAddr  in  ADDR_W  start address
- progCount  in  COUNT_W  transfers-1
- progMode  in  3  [0] dir (0 mem->io: MEMR_N+IOW_N; 1 io->mem: IOR_N+MEMW_N), [1] autoInit, [2] decrement
- progAccept  out  1  progValid was taken this cycle
- statusRead  in  1  clears tcStatus next cycle
- HRQ  out  1  hold request
- DACK  out  NUM_CH  one-hot acknowledge
- AEN  out  1  address enable
- ADSTB  out  1  address strobe
- ADDR  out  ADDR_W  transfer address
- MEMR_N, MEMW_N, IOR_N, IOW_N  out  1 each  active-low strobes
- TC  out  1  terminal-count pulse
- tcStatus  out  NUM_CH  sticky TC per channel
- armed  out  NUM_CH  channel has a programmed, unfinished transfer

Behaviour:
- Reset (async, any state):
  - state=SI; HRQ=0; DACK=0; AEN=0; ADSTB=0; ADDR=0; all strobes=1; TC=0.
  - tcStatus=0; armed=0; all address/count registers=0; priority order ch0>ch1>...>chN-1.
- Outputs decode from the registered state (Moore). HRQ=1 in S0..S4.
  - S1: AEN=1, ADSTB=1, ADDR=current address of the granted channel.
  - S2..S4: AEN=1, ADDR held, DACK[grant]=1.
  - Read strobe (MEMR_N or IOR_N per dir) =0 in S2, S3, S4. Write strobe (IOW_N or MEMW_N) =0 in S3, S4.
- Eligible[i] = DREQ[i] & armed[i].
- SI: any eligible -> S0 next edge, otherwise stay.
- S0: wait while HLDA=0 and any eligible.
  - No eligible -> SI (HRQ drops).
  - HLDA=1 and eligible -> S1; grant latched on this edge = highest-priority eligible channel in the current order.
- S1->S2->S3->S4->SI unconditionally. HLDA and DREQ are ignored after the grant; the transfer always completes.
- S4 update, applied on the S4->SI edge:
  - Address: +1, or -1 if decrement; wraps modulo 2^ADDR_W.
  - If current count==0: TC=1 during S4; tcStatus[grant] set.
    - autoInit: current address/count reload from base; armed stays 1.
    - Otherwise armed[grant] cleared.
  - If current count!=0: count-1.
- Rotating priority: on the S4->SI edge the serviced channel becomes lowest and the next channel highest. Fixed priority never changes order. Switching rotatePriority to 0 restores the ch0-highest order immediately.
- Programming:
  - Accepted only in SI, or in S0 before the grant edge (progAccept=1 that cycle); ignored in S1..S4 (progAccept=0).
  - Accept writes base=current address and count, stores the mode, sets armed[ch], clears tcStatus[ch].
  - Programming and arbitration in the same S0 cycle: the arbitration uses pre-write armed values.
- statusRead clears all tcStatus bits.
  - If a TC set lands on the same edge, the set wins for that channel.
- Minimum cycle: DREQ high at edge k -> HRQ at k+1, S1 at k+2 if HLDA already high, TC at k+5, SI at k+6.

Test Plan:
- Reset mid-S3, ch1 active -> next sample all outputs at reset values, armed=0, state SI.
- Fixed priority: program ch0 and ch2 (count 0); DREQ=0101, HLDA=1 -> DACK=0001 first; then DACK=0100; TC pulses each; tcStatus=0101; armed=0000.
- Rotating priority: all channels armed count 3; DREQ=1111 held, HLDA=1 -> DACK sequence 0001, 0010, 0100, 1000, 0001.
- ch3 addr 16'h0010, count 2, decrement, dir=1 -> ADDR 0010, 000F, 000E; IOR_N low in S2..S4 and MEMW_N low in S3..S4 of each transfer; TC only on the third.
- autoInit: ch1 addr 16'hFFFF, count 1 -> ADDR FFFF, 0000; TC on the second; ch1 stays armed; the next transfer ADDR is FFFF again.
- HLDA held 0 in S0, DREQ drops -> SI and HRQ=0. progValid during S2 -> progAccept=0, registers unchanged.
